// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a framed byte stream (2-byte little-endian word
// count, payload, 1-byte XOR checksum), packs the payload into little-endian
// 32-bit words and writes them sequentially into instruction memory. The
// pipeline core is held in reset until a complete, checksum-verified image
// has been loaded. A start pulse in DONE or ERROR begins a fresh load.
module imem_boot_loader #(
   parameter int ADDR_WIDTH = 10,
   parameter int MAX_WORDS  = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   input  logic                  start,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  core_rst,
   output logic                  done,
   output logic                  error,
   output logic [15:0]           word_count
);

   // Size limit widened by one bit so a 16-bit length can never wrap in the compare
   localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

   typedef enum logic [2:0] {
      ST_LEN0  = 3'd0,
      ST_LEN1  = 3'd1,
      ST_DATA  = 3'd2,
      ST_CSUM  = 3'd3,
      ST_DONE  = 3'd4,
      ST_ERROR = 3'd5
   } state_e;

   state_e                  state_q,      state_d;
   logic [1:0]              byte_idx_q,   byte_idx_d;
   logic [15:0]             word_idx_q,   word_idx_d;
   logic [7:0]              csum_q,       csum_d;
   logic [23:0]             asm_q,        asm_d;
   logic                    imem_we_q,    imem_we_d;
   logic [ADDR_WIDTH-1:0]   imem_addr_q,  imem_addr_d;
   logic [31:0]             imem_wdata_q, imem_wdata_d;
   logic [15:0]             word_count_q, word_count_d;
   logic                    done_q,       done_d;
   logic                    error_q,      error_d;
   logic                    core_rst_q,   core_rst_d;
   logic                    byte_ready_q, byte_ready_d;

   logic                    accept_s;
   logic [15:0]             len_s;

   assign accept_s = byte_valid & byte_ready_q;
   // Full length as it becomes known on the second header byte
   assign len_s    = {byte_data, word_count_q[7:0]};

   // Next-state and next-output computation for the loader FSM
   always_comb begin
      state_d      = state_q;
      byte_idx_d   = byte_idx_q;
      word_idx_d   = word_idx_q;
      csum_d       = csum_q;
      asm_d        = asm_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      word_count_d = word_count_q;
      done_d       = done_q;
      error_d      = error_q;
      core_rst_d   = core_rst_q;
      byte_ready_d = byte_ready_q;

      case (state_q)
         ST_LEN0: begin
            if (accept_s) begin
               word_count_d[7:0] = byte_data;
               state_d           = ST_LEN1;
            end else begin
               state_d = ST_LEN0;
            end
         end

         ST_LEN1: begin
            if (accept_s) begin
               word_count_d = len_s;
               if (len_s == 16'd0) begin
                  state_d = ST_CSUM;
               end else if ({1'b0, len_s} > MAX_W) begin
                  state_d      = ST_ERROR;
                  error_d      = 1'b1;
                  core_rst_d   = 1'b1;
                  byte_ready_d = 1'b0;
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               state_d = ST_LEN1;
            end
         end

         ST_DATA: begin
            if (accept_s) begin
               csum_d     = csum_q ^ byte_data;
               byte_idx_d = byte_idx_q + 2'd1;
               case (byte_idx_q)
                  2'd0: asm_d[7:0]   = byte_data;
                  2'd1: asm_d[15:8]  = byte_data;
                  2'd2: asm_d[23:16] = byte_data;
                  default: begin
                     // Fourth byte completes the word: register the write
                     imem_we_d    = 1'b1;
                     imem_wdata_d = {byte_data, asm_q};
                     imem_addr_d  = word_idx_q[ADDR_WIDTH-1:0];
                     word_idx_d   = word_idx_q + 16'd1;
                     if (word_idx_q == (word_count_q - 16'd1)) begin
                        state_d = ST_CSUM;
                     end else begin
                        state_d = ST_DATA;
                     end
                  end
               endcase
            end else begin
               state_d = ST_DATA;
            end
         end

         ST_CSUM: begin
            if (accept_s) begin
               byte_ready_d = 1'b0;
               if (byte_data == csum_q) begin
                  state_d    = ST_DONE;
                  done_d     = 1'b1;
                  core_rst_d = 1'b0;
               end else begin
                  state_d    = ST_ERROR;
                  error_d    = 1'b1;
                  core_rst_d = 1'b1;
               end
            end else begin
               state_d = ST_CSUM;
            end
         end

         ST_DONE, ST_ERROR: begin
            if (start) begin
               // Fresh load; instruction memory contents are left intact
               state_d      = ST_LEN0;
               core_rst_d   = 1'b1;
               done_d       = 1'b0;
               error_d      = 1'b0;
               byte_idx_d   = 2'd0;
               word_idx_d   = 16'd0;
               csum_d       = 8'd0;
               asm_d        = 24'd0;
               byte_ready_d = 1'b1;
            end else begin
               state_d = state_q;
            end
         end

         default: begin
            // Unreachable encoding: park safely with the core held in reset
            state_d      = ST_ERROR;
            error_d      = 1'b1;
            done_d       = 1'b0;
            core_rst_d   = 1'b1;
            byte_ready_d = 1'b0;
         end
      endcase
   end

   // State and output registers; async reset discards any partial word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_LEN0;
         byte_idx_q   <= 2'd0;
         word_idx_q   <= 16'd0;
         csum_q       <= 8'd0;
         asm_q        <= 24'd0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= 32'd0;
         word_count_q <= 16'd0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         core_rst_q   <= 1'b1;
         byte_ready_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         byte_idx_q   <= byte_idx_d;
         word_idx_q   <= word_idx_d;
         csum_q       <= csum_d;
         asm_q        <= asm_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         word_count_q <= word_count_d;
         done_q       <= done_d;
         error_q      <= error_d;
         core_rst_q   <= core_rst_d;
         byte_ready_q <= byte_ready_d;
      end
   end

   assign byte_ready = byte_ready_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign core_rst   = core_rst_q;
   assign done       = done_q;
   assign error      = error_q;
   assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: directed frames, an expected-write queue
// derived from the frame bytes, a per-cycle compare process, and literal pins.
module tb_imem_boot_loader;

   localparam int AW   = 10;
   localparam int MAXW = 1024;

   logic          clk = 1'b0;
   logic          rst;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;
   logic          start;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          core_rst;
   logic          done;
   logic          error;
   logic [15:0]   word_count;

   imem_boot_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
      .clk        (clk),
      .rst        (rst),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .start      (start),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_rst   (core_rst),
      .done       (done),
      .error      (error),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          addr;
      logic [31:0] data;
      int          due;
   } wr_t;

   wr_t          exp_q[$];
   logic [41:0]  wr_log[$];
   logic [7:0]   frame_q[$];
   int           total = 0;
   int           bad   = 0;
   bit           chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Per-cycle compare of write strobes and status invariants
   always @(negedge clk) begin : cmp
      wr_t e;
      if (chk_en && !rst) begin
         if (imem_we) begin
            wr_log.push_back({imem_addr, imem_wdata});
            if (exp_q.size() == 0) begin
               chk("spurious_we", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("we_addr", 32'(imem_addr), 32'(e.addr));
               chk("we_data", imem_wdata, e.data);
               chk("we_cycle", 32'(cyc), 32'(e.due));
            end
         end else if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
            chk("missing_we", 32'd0, 32'd1);
            e = exp_q.pop_front();
         end
         chk("core_rst_vs_done", 32'(core_rst), 32'(!done));
         chk("done_error_excl", 32'(done & error), 32'd0);
      end
   end

   task automatic check_reset_vals(input string tag);
      chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd1);
      chk({tag, "_imem_we"},    32'(imem_we),    32'd0);
      chk({tag, "_imem_addr"},  32'(imem_addr),  32'd0);
      chk({tag, "_imem_wdata"}, imem_wdata,      32'd0);
      chk({tag, "_core_rst"},   32'(core_rst),   32'd1);
      chk({tag, "_done"},       32'(done),       32'd0);
      chk({tag, "_error"},      32'(error),      32'd0);
      chk({tag, "_word_count"}, 32'(word_count), 32'd0);
   endtask

   // Present one byte at a negedge and hold it until accepted; acc_c is the
   // cycle count just before the accepting edge.
   task automatic send_byte(input logic [7:0] b, output int acc_c);
      int k;
      k = 0;
      @(negedge clk);
      start      = 1'b0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!byte_ready) chk("ready_timeout", 32'd0, 32'd1);
      acc_c = cyc;
   endtask

   // Send frame_q, building the expected writes and final outcome from the bytes
   task automatic run_frame(input bit gaps);
      int          len, n, c, p, g;
      bit          over, ok;
      logic [7:0]  cs;
      logic [31:0] asmw;
      len  = int'({frame_q[1], frame_q[0]});
      over = (len > MAXW);
      n    = over ? 2 : frame_q.size();
      cs   = 8'd0;
      asmw = 32'd0;
      for (int i = 0; i < n; i++) begin
         if (gaps && i > 0) begin
            g = int'($urandom_range(1, 3));
            for (int j = 0; j < g; j++) begin
               @(negedge clk);
               byte_valid = 1'b0;
               byte_data  = 8'($urandom);
               start      = (i == 4 && j == 0);
            end
         end
         send_byte(frame_q[i], c);
         p = i - 2;
         if (!over && i >= 2 && p < 4 * len) begin
            asmw[8*(p%4) +: 8] = frame_q[i];
            cs = cs ^ frame_q[i];
            if (p % 4 == 3) exp_q.push_back('{p / 4, asmw, c + 1});
         end
      end
      @(negedge clk);
      byte_valid = 1'b0;
      ok = !over && (frame_q[n-1] == cs);
      chk("final_done",       32'(done),       32'(ok));
      chk("final_error",      32'(error),      32'(!ok));
      chk("final_core_rst",   32'(core_rst),   32'(!ok));
      chk("final_byte_ready", 32'(byte_ready), 32'd0);
      chk("final_word_count", 32'(word_count), 32'(len));
      chk("writes_pending",   32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_done",       32'(done),       32'd0);
      chk("start_error",      32'(error),      32'd0);
      chk("start_core_rst",   32'(core_rst),   32'd1);
      chk("start_byte_ready", 32'(byte_ready), 32'd1);
   endtask

   initial begin
      int c;
      rst        = 1'b1;
      byte_valid = 1'b0;
      byte_data  = 8'd0;
      start      = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_vals("rst_held");
      rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      check_reset_vals("rst_released");

      // Nominal 2-word load
      wr_log.delete();
      frame_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                  8'h93, 8'h00, 8'h50, 8'h00, 8'hD0};
      run_frame(1'b0);
      chk("t1_nwrites", 32'(wr_log.size()), 32'd2);
      if (wr_log.size() >= 2) begin
         chk("t1_w0_addr", 32'(wr_log[0][41:32]), 32'd0);
         chk("t1_w0_data", wr_log[0][31:0],       32'h00000013);
         chk("t1_w1_addr", 32'(wr_log[1][41:32]), 32'd1);
         chk("t1_w1_data", wr_log[1][31:0],       32'h00500093);
      end
      chk("t1_done",     32'(done),       32'd1);
      chk("t1_word_cnt", 32'(word_count), 32'd2);

      // Same stream with gaps (and an ignored mid-frame start pulse)
      do_start();
      wr_log.delete();
      run_frame(1'b1);
      chk("t2_nwrites", 32'(wr_log.size()), 32'd2);

      // Bad checksum
      do_start();
      wr_log.delete();
      frame_q[10] = 8'hD1;
      run_frame(1'b0);
      chk("t3_nwrites", 32'(wr_log.size()), 32'd2);
      chk("t3_error",   32'(error),         32'd1);
      chk("t3_core_rst", 32'(core_rst),     32'd1);

      // Zero length
      do_start();
      wr_log.delete();
      frame_q = '{8'h00, 8'h00, 8'h00};
      run_frame(1'b0);
      chk("t4_nwrites", 32'(wr_log.size()), 32'd0);
      chk("t4_done",    32'(done),          32'd1);

      // Oversize: 1025 words
      do_start();
      wr_log.delete();
      frame_q = '{8'h01, 8'h04};
      run_frame(1'b0);
      chk("t5_nwrites", 32'(wr_log.size()), 32'd0);
      chk("t5_error",   32'(error),         32'd1);
      chk("t5_word_cnt", 32'(word_count),   32'd1025);

      // Reload a 1-word image
      do_start();
      wr_log.delete();
      frame_q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
      run_frame(1'b0);
      chk("t6_nwrites", 32'(wr_log.size()), 32'd1);
      if (wr_log.size() >= 1) begin
         chk("t6_w0_addr", 32'(wr_log[0][41:32]), 32'd0);
         chk("t6_w0_data", wr_log[0][31:0],       32'hDEADBEEF);
      end
      chk("t6_done", 32'(done), 32'd1);

      // Reset after 3 payload bytes, then a fresh load
      do_start();
      wr_log.delete();
      frame_q = '{8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC};
      for (int i = 0; i < 5; i++) send_byte(frame_q[i], c);
      @(negedge clk);
      byte_valid = 1'b0;
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check_reset_vals("midrst");
      chk("t7_nwrites", 32'(wr_log.size()), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      frame_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                  8'h93, 8'h00, 8'h50, 8'h00, 8'hD0};
      run_frame(1'b0);
      chk("t7_reload_nwrites", 32'(wr_log.size()), 32'd2);
      chk("t7_reload_done",    32'(done),          32'd1);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog so the bench always terminates
   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
